store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
Store address/data preparation stage directly upstream of the store buffer.
- Accepts one store op at a time from issue and checks alignment.
- Requests address translation from the MMU, then builds byte-enables and lane-shifted data.
- Pushes the store into the store buffer only when the buffer can take it, and reports completion or exception to writeback.

Parameters:
XLEN, 64, data path width; only 64 is supported (byte offset = vaddr[2:0]).
PLEN, 56, physical address width; matches store-buffer paddr.
TRANS_ID_BITS, 3, scoreboard transaction-id width.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock, reset is synchronous and active-high
flush_i  in  1  pipeline flush; drops the in-flight store
valid_i  in  1  store request valid
ready_o  out  1  unit idle, can accept a request
vaddr_i  in  XLEN  store virtual address
data_i  in  XLEN  store data, right-aligned
size_i  in  2  00 byte, 01 half, 10 word, 11 dword
trans_id_i  in  TRANS_ID_BITS  scoreboard id
translation_req_o  out  1  MMU request
vaddr_o  out  XLEN  address to MMU
translation_valid_i  in  1  MMU response valid
paddr_i  in  PLEN  translated address
page_fault_i  in  1  MMU fault, qualified by translation_valid_i
st_ready_i  in  1  store buffer has space
st_valid_o  out  1  push to store buffer
st_valid_without_flush_o  out  1  push candidate, not gated by flush
st_paddr_o  out  PLEN  physical address
st_data_o  out  XLEN  lane-aligned data
st_be_o  out  XLEN/8  byte enables
st_data_size_o  out  2  size passthrough
result_valid_o  out  1  completion pulse
result_trans_id_o  out  TRANS_ID_BITS  id of completed op
result_xcpt_o  out  1  exception flag
result_xcpt_cause_o  out  4  6 = store misaligned, 15 = store page fault
result_tval_o  out  XLEN  faulting vaddr

Behaviour:
- FSM states: IDLE, WAIT_TRANS, WAIT_SB, REPORT_XCPT.
- ready_o = (state == IDLE).
- Accept condition: valid_i & ready_o & !flush_i. On accept, latch vaddr, data, size and id.
- Misalignment on accept: half with vaddr[0] != 0; word with vaddr[1:0] != 0; dword with vaddr[2:0] != 0.
  - Misaligned: go to REPORT_XCPT, cause 6, no MMU request.
  - Aligned: go to WAIT_TRANS.
- Byte enables, with o = vaddr[2:0]: byte = 8'h01<<o; half = 8'h03<<o; word = 8'h0F<<o; dword = 8'hFF. All shifts are truncated to 8 bits.
- st_data_o = data << (8*o), truncated to XLEN.
- WAIT_TRANS: translation_req_o = 1 and vaddr_o = latched vaddr.
  - On translation_valid_i with page_fault_i: go to REPORT_XCPT, cause 15.
  - On translation_valid_i without fault: latch paddr_i and go to WAIT_SB.
- WAIT_SB:
  - st_valid_without_flush_o = st_ready_i.
  - st_valid_o = st_ready_i & !flush_i.
  - When st_valid_o is high: result_valid_o = 1 the same cycle with result_xcpt_o = 0, then go to IDLE.
  - While st_ready_i = 0, hold in WAIT_SB with outputs stable.
- REPORT_XCPT: for one cycle, result_valid_o = 1, result_xcpt_o = 1, result_tval_o = vaddr; then go to IDLE. st_valid_o is never asserted for a faulting op.
- Latency:
  - Best case: accept at T, translation_valid_i at T+1, st_valid_o and result at T+2.
  - Misaligned op: result at T+1.
- flush_i in any state: next state IDLE; st_valid_o and result_valid_o are 0 that cycle; translation_req_o deasserts the following cycle. A translation_valid_i arriving in IDLE is ignored.
- A request presented with flush_i high is not accepted.
- Reset: state IDLE; every output 0 except ready_o = 1 after the reset cycle.
- st_paddr_o, st_data_o, st_be_o and st_data_size_o are registered and stable throughout WAIT_SB.
- No outstanding-request counter: at most one op in flight.

Test Plan:
- Aligned dword: vaddr 0x1000, data 0x1122334455667788; MMU returns paddr 0x80001000 one cycle later, st_ready_i = 1 -> st_valid_o at T+2 with be = 0xFF, paddr 0x80001000; result_valid_o in the same cycle with xcpt = 0.
- Byte at vaddr 0x1005, data 0xAB -> be = 0x20, st_data_o = 0x0000AB0000000000, st_data_size_o = 00.
- Half at vaddr 0x1003 -> no translation_req_o; result_valid_o at T+1 with xcpt = 1, cause 6, tval 0x1003; st_valid_o never asserted.
- Page fault: MMU answers with page_fault_i = 1 -> result cause 15, tval = vaddr; no store-buffer push.
- Store-buffer back-pressure: st_ready_i low for 3 cycles after translation -> unit holds in WAIT_SB with stable outputs and ready_o = 0; pushes on the first cycle st_ready_i is high.
- flush_i asserted in WAIT_SB with st_ready_i = 1 -> st_valid_o = 0, st_valid_without_flush_o = 1, no result, ready_o = 1 next cycle.
- rst_i asserted mid-WAIT_TRANS -> state returns to IDLE with all outputs cleared.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: store address/data preparation ahead of the store buffer.
// Takes one store at a time, checks alignment, requests address translation,
// builds the byte enables and the lane-aligned data, then pushes into the store
// buffer and reports completion or an exception to writeback.
module store_unit #(
   parameter int unsigned XLEN          = 64,
   parameter int unsigned PLEN          = 56,
   parameter int unsigned TRANS_ID_BITS = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [XLEN-1:0]          vaddr_i,
   input  logic [XLEN-1:0]          data_i,
   input  logic [1:0]               size_i,
   input  logic [TRANS_ID_BITS-1:0] trans_id_i,
   output logic                     translation_req_o,
   output logic [XLEN-1:0]          vaddr_o,
   input  logic                     translation_valid_i,
   input  logic [PLEN-1:0]          paddr_i,
   input  logic                     page_fault_i,
   input  logic                     st_ready_i,
   output logic                     st_valid_o,
   output logic                     st_valid_without_flush_o,
   output logic [PLEN-1:0]          st_paddr_o,
   output logic [XLEN-1:0]          st_data_o,
   output logic [XLEN/8-1:0]        st_be_o,
   output logic [1:0]               st_data_size_o,
   output logic                     result_valid_o,
   output logic [TRANS_ID_BITS-1:0] result_trans_id_o,
   output logic                     result_xcpt_o,
   output logic [3:0]               result_xcpt_cause_o,
   output logic [XLEN-1:0]          result_tval_o
);

   localparam int unsigned BE_W = XLEN / 8;
   localparam logic [3:0] CAUSE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_PAGE_FAULT = 4'd15;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_TRANS,
      WAIT_SB,
      REPORT_XCPT
   } state_e;

   state_e                     state_q;
   logic [XLEN-1:0]            vaddr_q;
   logic [XLEN-1:0]            data_q;
   logic [BE_W-1:0]            be_q;
   logic [1:0]                 size_q;
   logic [TRANS_ID_BITS-1:0]   id_q;
   logic [PLEN-1:0]            paddr_q;
   logic [3:0]                 cause_q;

   logic [XLEN-1:0]            data_d;
   logic [BE_W-1:0]            be_d;
   logic                       misaligned;

   // Alignment check, byte-enable and lane shift computed from the incoming request
   always_comb begin
      misaligned = 1'b0;
      be_d       = '0;
      case (size_i)
         2'b00: begin
            be_d = BE_W'(8'h01) << vaddr_i[2:0];
         end
         2'b01: begin
            misaligned = vaddr_i[0];
            be_d       = BE_W'(8'h03) << vaddr_i[2:0];
         end
         2'b10: begin
            misaligned = |vaddr_i[1:0];
            be_d       = BE_W'(8'h0F) << vaddr_i[2:0];
         end
         default: begin
            misaligned = |vaddr_i[2:0];
            be_d       = BE_W'(8'hFF);
         end
      endcase
      data_d = data_i << {vaddr_i[2:0], 3'b000};
   end

   // Control FSM plus the registered request/translation payload
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         vaddr_q <= '0;
         data_q  <= '0;
         be_q    <= '0;
         size_q  <= '0;
         id_q    <= '0;
         paddr_q <= '0;
         cause_q <= '0;
      end else if (flush_i) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  vaddr_q <= vaddr_i;
                  data_q  <= data_d;
                  be_q    <= be_d;
                  size_q  <= size_i;
                  id_q    <= trans_id_i;
                  cause_q <= CAUSE_MISALIGNED;
                  state_q <= misaligned ? REPORT_XCPT : WAIT_TRANS;
               end
            end
            WAIT_TRANS: begin
               if (translation_valid_i) begin
                  if (page_fault_i) begin
                     cause_q <= CAUSE_PAGE_FAULT;
                     state_q <= REPORT_XCPT;
                  end else begin
                     paddr_q <= paddr_i;
                     state_q <= WAIT_SB;
                  end
               end
            end
            WAIT_SB: begin
               if (st_ready_i) state_q <= IDLE;
            end
            REPORT_XCPT: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Push and completion are same-cycle handshakes, so they are decoded from state and inputs
   assign ready_o                  = (state_q == IDLE);
   assign translation_req_o        = (state_q == WAIT_TRANS);
   assign vaddr_o                  = vaddr_q;
   assign st_valid_without_flush_o = (state_q == WAIT_SB) & st_ready_i;
   assign st_valid_o               = (state_q == WAIT_SB) & st_ready_i & ~flush_i;
   assign st_paddr_o               = paddr_q;
   assign st_data_o                = data_q;
   assign st_be_o                  = be_q;
   assign st_data_size_o           = size_q;
   assign result_xcpt_o            = (state_q == REPORT_XCPT) & ~flush_i;
   assign result_valid_o           = st_valid_o | result_xcpt_o;
   assign result_trans_id_o        = id_q;
   assign result_xcpt_cause_o      = result_xcpt_o ? cause_q : 4'd0;
   assign result_tval_o            = (state_q == REPORT_XCPT) ? vaddr_q : '0;

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scenarios plus randomized store ops checked against
// a byte-level reference model of alignment, byte enables and lane placement.
module tb_store_unit;

   localparam int unsigned XLEN = 64;
   localparam int unsigned PLEN = 56;
   localparam int unsigned TIDW = 3;

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            flush_i = 1'b0;
   logic            valid_i = 1'b0;
   logic            ready_o;
   logic [XLEN-1:0] vaddr_i = '0;
   logic [XLEN-1:0] data_i = '0;
   logic [1:0]      size_i = '0;
   logic [TIDW-1:0] trans_id_i = '0;
   logic            translation_req_o;
   logic [XLEN-1:0] vaddr_o;
   logic            translation_valid_i = 1'b0;
   logic [PLEN-1:0] paddr_i = '0;
   logic            page_fault_i = 1'b0;
   logic            st_ready_i = 1'b0;
   logic            st_valid_o;
   logic            st_valid_without_flush_o;
   logic [PLEN-1:0] st_paddr_o;
   logic [XLEN-1:0] st_data_o;
   logic [7:0]      st_be_o;
   logic [1:0]      st_data_size_o;
   logic            result_valid_o;
   logic [TIDW-1:0] result_trans_id_o;
   logic            result_xcpt_o;
   logic [3:0]      result_xcpt_cause_o;
   logic [XLEN-1:0] result_tval_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   store_unit #(.XLEN(XLEN), .PLEN(PLEN), .TRANS_ID_BITS(TIDW)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .vaddr_i(vaddr_i), .data_i(data_i), .size_i(size_i), .trans_id_i(trans_id_i),
      .translation_req_o(translation_req_o), .vaddr_o(vaddr_o),
      .translation_valid_i(translation_valid_i), .paddr_i(paddr_i), .page_fault_i(page_fault_i),
      .st_ready_i(st_ready_i), .st_valid_o(st_valid_o),
      .st_valid_without_flush_o(st_valid_without_flush_o), .st_paddr_o(st_paddr_o),
      .st_data_o(st_data_o), .st_be_o(st_be_o), .st_data_size_o(st_data_size_o),
      .result_valid_o(result_valid_o), .result_trans_id_o(result_trans_id_o),
      .result_xcpt_o(result_xcpt_o), .result_xcpt_cause_o(result_xcpt_cause_o),
      .result_tval_o(result_tval_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: number of bytes the access covers
   function automatic int unsigned nbytes(input logic [1:0] sz);
      return 32'd1 << sz;
   endfunction

   function automatic bit ref_misaligned(input logic [1:0] sz, input logic [63:0] va);
      return (va % nbytes(sz)) != 0;
   endfunction

   // Reference: mark each covered byte lane, dropping lanes beyond the doubleword
   function automatic logic [7:0] ref_be(input logic [1:0] sz, input logic [63:0] va);
      logic [7:0] r = '0;
      int unsigned off = va % 8;
      if (sz == 2'b11) return 8'hFF;
      for (int unsigned i = 0; i < nbytes(sz); i++)
         if (off + i < 8) r[off + i] = 1'b1;
      return r;
   endfunction

   // Reference: move each source byte k to lane k+offset
   function automatic logic [63:0] ref_data(input logic [63:0] d, input logic [63:0] va);
      logic [63:0] r = '0;
      int unsigned off = va % 8;
      for (int unsigned k = 0; k + off < 8; k++)
         r[(k + off) * 8 +: 8] = d[k * 8 +: 8];
      return r;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // One full store op; entered and left at posedge+1 with the unit idle
   task automatic do_op(input logic [63:0] va, input logic [63:0] d, input logic [1:0] sz,
                        input logic [TIDW-1:0] id, input bit fault, input logic [PLEN-1:0] pa,
                        input int unsigned lat, input int unsigned bp, input bit fl);
      bit          mis = ref_misaligned(sz, va);
      logic [7:0]  ebe = ref_be(sz, va);
      logic [63:0] edata = ref_data(d, va);
      check("idle_ready", ready_o, 1);
      valid_i = 1'b1; vaddr_i = va; data_i = d; size_i = sz; trans_id_i = id;
      @(negedge clk);
      check("acc_treq", translation_req_o, 0);
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (mis) begin
         @(negedge clk);
         check("mis_rvalid", result_valid_o, 1);
         check("mis_xcpt", result_xcpt_o, 1);
         check("mis_cause", result_xcpt_cause_o, 6);
         check("mis_tval", result_tval_o, va);
         check("mis_id", result_trans_id_o, id);
         check("mis_treq", translation_req_o, 0);
         check("mis_stvalid", st_valid_o, 0);
         @(posedge clk); #1;
         check("mis_ready_after", ready_o, 1);
      end else begin
         for (int unsigned i = 0; i < lat; i++) begin
            @(negedge clk);
            check("wt_treq", translation_req_o, 1);
            check("wt_ready", ready_o, 0);
            check("wt_rvalid", result_valid_o, 0);
            @(posedge clk); #1;
         end
         translation_valid_i = 1'b1; page_fault_i = fault; paddr_i = pa;
         @(negedge clk);
         check("wt_treq", translation_req_o, 1);
         check("wt_vaddr", vaddr_o, va);
         @(posedge clk); #1;
         translation_valid_i = 1'b0; page_fault_i = 1'b0;
         if (fault) begin
            @(negedge clk);
            check("pf_rvalid", result_valid_o, 1);
            check("pf_xcpt", result_xcpt_o, 1);
            check("pf_cause", result_xcpt_cause_o, 15);
            check("pf_tval", result_tval_o, va);
            check("pf_id", result_trans_id_o, id);
            check("pf_stvalid", st_valid_o, 0);
            check("pf_treq", translation_req_o, 0);
            @(posedge clk); #1;
            check("pf_ready_after", ready_o, 1);
         end else begin
            for (int unsigned i = 0; i < bp; i++) begin
               @(negedge clk);
               check("bp_stvalid", st_valid_o, 0);
               check("bp_stvwf", st_valid_without_flush_o, 0);
               check("bp_rvalid", result_valid_o, 0);
               check("bp_ready", ready_o, 0);
               check("bp_paddr", st_paddr_o, pa);
               check("bp_be", st_be_o, ebe);
               check("bp_data", st_data_o, edata);
               @(posedge clk); #1;
            end
            st_ready_i = 1'b1; flush_i = fl;
            @(negedge clk);
            check("sb_stvalid", st_valid_o, !fl);
            check("sb_stvwf", st_valid_without_flush_o, 1);
            check("sb_rvalid", result_valid_o, !fl);
            check("sb_xcpt", result_xcpt_o, 0);
            check("sb_treq", translation_req_o, 0);
            check("sb_paddr", st_paddr_o, pa);
            check("sb_be", st_be_o, ebe);
            check("sb_data", st_data_o, edata);
            check("sb_size", st_data_size_o, sz);
            if (!fl) check("sb_id", result_trans_id_o, id);
            @(posedge clk); #1;
            st_ready_i = 1'b0; flush_i = 1'b0;
            check("sb_ready_after", ready_o, 1);
         end
      end
   endtask

   initial begin
      logic [63:0] va;
      logic [1:0]  sz;
      rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;
      check("rst_ready", ready_o, 1);
      check("rst_treq", translation_req_o, 0);
      check("rst_stvalid", st_valid_o, 0);
      check("rst_rvalid", result_valid_o, 0);
      check("rst_be", st_be_o, 0);
      check("rst_paddr", st_paddr_o, 0);

      // Directed scenarios
      do_op(64'h1000, 64'h1122334455667788, 2'b11, 3'd1, 1'b0, 56'h80001000, 0, 0, 1'b0);
      do_op(64'h1005, 64'h00000000000000AB, 2'b00, 3'd2, 1'b0, 56'h80001005, 0, 0, 1'b0);
      check("byte_data_lit", st_data_o, 64'h0000AB0000000000);
      check("byte_be_lit", st_be_o, 8'h20);
      do_op(64'h1003, 64'h1234, 2'b01, 3'd3, 1'b0, '0, 0, 0, 1'b0);
      do_op(64'h2008, 64'hDEADBEEF, 2'b10, 3'd4, 1'b1, 56'h0, 1, 0, 1'b0);
      do_op(64'h3004, 64'hCAFEF00D, 2'b10, 3'd5, 1'b0, 56'h90003004, 0, 3, 1'b0);
      do_op(64'h4002, 64'h5566, 2'b01, 3'd6, 1'b0, 56'hA0004002, 0, 1, 1'b1);

      // Request with flush high is not accepted
      valid_i = 1'b1; flush_i = 1'b1; vaddr_i = 64'h5000; size_i = 2'b11;
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b0;
      check("flushreq_ready", ready_o, 1);
      check("flushreq_treq", translation_req_o, 0);

      // Flush in WAIT_TRANS, then a stray MMU response in IDLE is ignored
      valid_i = 1'b1; vaddr_i = 64'h6000; size_i = 2'b11; trans_id_i = 3'd7;
      @(posedge clk); #1;
      valid_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      check("fwt_treq_hold", translation_req_o, 1);
      check("fwt_rvalid", result_valid_o, 0);
      @(posedge clk); #1;
      flush_i = 1'b0;
      check("fwt_treq_off", translation_req_o, 0);
      check("fwt_ready", ready_o, 1);
      translation_valid_i = 1'b1; paddr_i = 56'h123;
      @(posedge clk); #1;
      translation_valid_i = 1'b0;
      check("stray_ready", ready_o, 1);
      check("stray_rvalid", result_valid_o, 0);
      check("stray_stvalid", st_valid_o, 0);

      // Reset in WAIT_TRANS
      valid_i = 1'b1; vaddr_i = 64'h7010; data_i = 64'h77; size_i = 2'b00; trans_id_i = 3'd5;
      @(posedge clk); #1;
      valid_i = 1'b0; rst_i = 1'b1;
      check("rstwt_treq_before", translation_req_o, 1);
      @(posedge clk); #1;
      rst_i = 1'b0;
      check("rstwt_ready", ready_o, 1);
      check("rstwt_treq", translation_req_o, 0);
      check("rstwt_vaddr", vaddr_o, 0);
      check("rstwt_be", st_be_o, 0);
      check("rstwt_data", st_data_o, 0);
      check("rstwt_id", result_trans_id_o, 0);
      check("rstwt_rvalid", result_valid_o, 0);

      // Randomized ops
      for (int unsigned n = 0; n < 200; n++) begin
         sz = 2'($urandom_range(0, 3));
         va = rnd64();
         if ($urandom_range(0, 3) != 0) va = va & ~64'((nbytes(sz)) - 1);
         do_op(va, rnd64(), sz, TIDW'($urandom), ($urandom_range(0, 5) == 0),
               PLEN'(rnd64()), $urandom_range(0, 2), $urandom_range(0, 3),
               ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
